// File: rtl/tx_pkg.sv
// Shared types for the MAC TX stream arbiter: state encoding, grant codes, byte-interface widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tx_pkg;

  localparam int TX_DATA_W   = 8;
  localparam int PKT_CNT_W   = 16;
  localparam int ABORT_CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PKT   = 3'd1,
    ST_ABORT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_GAP   = 3'd4
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_S0   = 2'b01;
  localparam logic [1:0] GRANT_S1   = 2'b10;

  // Saturating increment used by the watchdog abort counter.
  function automatic logic [ABORT_CNT_W-1:0] sat_inc(input logic [ABORT_CNT_W-1:0] v);
    return (&v) ? v : v + ABORT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker; remembers the last source that completed a packet.
// Latency: pick is combinational from i_req; last-grant register updates on the next edge.
// Backpressure: none; the caller decides when a pick is taken and when the history advances.
module rr_arb2
  import tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_upd,
  input  logic [1:0] i_upd_gnt,
  output logic [1:0] o_gnt
);

  logic [1:0] r_last;

  // Last-grantee history; starts as s1 so s0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last <= GRANT_S1;
    end else if (i_upd) begin
      r_last <= i_upd_gnt;
    end
  end

  // On a tie the source that did not go last wins; otherwise the lone requester.
  always_comb begin
    o_gnt = GRANT_NONE;
    if (i_req == 2'b11) begin
      o_gnt = (r_last == GRANT_S0) ? GRANT_S1 : GRANT_S0;
    end else if (i_req[0]) begin
      o_gnt = GRANT_S0;
    end else if (i_req[1]) begin
      o_gnt = GRANT_S1;
    end
  end

endmodule

// File: rtl/tx_stream_arbiter.sv
// Two-source packet arbiter onto a MAC TX byte interface with inter-packet gap and length watchdog.
// Latency: zero-latency data path while a packet is granted; one IDLE cycle to arbitrate.
// Backpressure: granted source is ready only when the MAC is ready and not almost-full.
module tx_stream_arbiter
  import tx_pkg::*;
#(
  parameter int GAP_CYCLES = 2,
  parameter int MAX_LEN    = 1518
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s0_req,
  input  logic [TX_DATA_W-1:0]   s0_data,
  input  logic                   s0_sop,
  input  logic                   s0_eop,
  input  logic                   s0_err,
  input  logic                   s0_wren,
  output logic                   s0_rdy,
  input  logic                   s1_req,
  input  logic [TX_DATA_W-1:0]   s1_data,
  input  logic                   s1_sop,
  input  logic                   s1_eop,
  input  logic                   s1_err,
  input  logic                   s1_wren,
  output logic                   s1_rdy,
  output logic [TX_DATA_W-1:0]   tx_data,
  output logic                   tx_sop,
  output logic                   tx_eop,
  output logic                   tx_err,
  output logic                   tx_wren,
  input  logic                   tx_rdy,
  input  logic                   tx_a_full,
  output logic [PKT_CNT_W-1:0]   pkt_cnt0,
  output logic [PKT_CNT_W-1:0]   pkt_cnt1,
  output logic [ABORT_CNT_W-1:0] abort_cnt,
  output logic [1:0]             grant
);

  localparam int BEAT_W = $clog2(MAX_LEN + 1);
  localparam int GAP_W  = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_LEN - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  // With no gap configured a finished packet returns straight to arbitration.
  localparam arb_state_t ST_AFTER = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

  arb_state_t               r_state;
  arb_state_t               w_state_nxt;
  logic [1:0]               r_grant;
  logic [BEAT_W-1:0]        r_beat_cnt;
  logic [GAP_W-1:0]         r_gap_cnt;
  logic [PKT_CNT_W-1:0]     r_pkt_cnt0;
  logic [PKT_CNT_W-1:0]     r_pkt_cnt1;
  logic [ABORT_CNT_W-1:0]   r_abort_cnt;

  logic [1:0]               w_pick;
  logic                     w_grant_ld;
  logic                     w_xfer;
  logic                     w_pkt_done;
  logic                     w_drain_done;
  logic                     w_abort_done;
  logic                     w_src_rdy;
  logic [TX_DATA_W-1:0]     w_src_data;
  logic                     w_src_sop;
  logic                     w_src_eop;
  logic                     w_src_err;
  logic                     w_src_wren;

  // Granted source selection; r_grant holds its last value outside a packet but is unused there.
  assign w_src_data = r_grant[1] ? s1_data : s0_data;
  assign w_src_sop  = r_grant[1] ? s1_sop  : s0_sop;
  assign w_src_eop  = r_grant[1] ? s1_eop  : s0_eop;
  assign w_src_err  = r_grant[1] ? s1_err  : s0_err;
  assign w_src_wren = r_grant[1] ? s1_wren : s0_wren;

  assign pkt_cnt0  = r_pkt_cnt0;
  assign pkt_cnt1  = r_pkt_cnt1;
  assign abort_cnt = r_abort_cnt;

  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .rst       (rst),
    .i_req     ({s1_req, s0_req}),
    .i_upd     (w_pkt_done | w_drain_done),
    .i_upd_gnt (r_grant),
    .o_gnt     (w_pick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and all interface outputs; everything is forced quiet while reset is low.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_ld   = 1'b0;
    w_xfer       = 1'b0;
    w_pkt_done   = 1'b0;
    w_drain_done = 1'b0;
    w_abort_done = 1'b0;
    w_src_rdy    = 1'b0;
    grant        = GRANT_NONE;
    tx_data      = '0;
    tx_sop       = 1'b0;
    tx_eop       = 1'b0;
    tx_err       = 1'b0;
    tx_wren      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (s0_req | s1_req) begin
          w_grant_ld  = 1'b1;
          w_state_nxt = ST_PKT;
        end
      end
      ST_PKT: begin
        grant     = r_grant;
        w_src_rdy = tx_rdy & ~tx_a_full;
        tx_data   = w_src_data;
        tx_sop    = w_src_sop;
        tx_eop    = w_src_eop;
        tx_err    = w_src_err;
        tx_wren   = w_src_wren & ~tx_a_full;
        w_xfer    = tx_wren & tx_rdy;
        if (w_xfer) begin
          if (w_src_eop) begin
            w_pkt_done  = 1'b1;
            w_state_nxt = ST_AFTER;
          end else if (r_beat_cnt == BEAT_LAST) begin
            w_state_nxt = ST_ABORT;
          end
        end
      end
      ST_ABORT: begin
        // Terminate the runaway frame with an errored empty end-of-packet beat.
        grant   = r_grant;
        tx_eop  = 1'b1;
        tx_err  = 1'b1;
        tx_wren = 1'b1;
        if (tx_rdy) begin
          w_abort_done = 1'b1;
          w_state_nxt  = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Swallow the rest of the oversized frame so the source resyncs on its eop.
        grant     = r_grant;
        w_src_rdy = 1'b1;
        if (w_src_wren & w_src_eop) begin
          w_drain_done = 1'b1;
          w_state_nxt  = ST_AFTER;
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    s0_rdy = w_src_rdy & r_grant[0];
    s1_rdy = w_src_rdy & r_grant[1];
    if (!rst) begin
      w_grant_ld   = 1'b0;
      w_xfer       = 1'b0;
      w_pkt_done   = 1'b0;
      w_drain_done = 1'b0;
      w_abort_done = 1'b0;
      s0_rdy       = 1'b0;
      s1_rdy       = 1'b0;
      grant        = GRANT_NONE;
      tx_data      = '0;
      tx_sop       = 1'b0;
      tx_eop       = 1'b0;
      tx_err       = 1'b0;
      tx_wren      = 1'b0;
    end
  end

  // Capture the round-robin pick as the packet owner when leaving IDLE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_grant <= GRANT_NONE;
    end else if (w_grant_ld) begin
      r_grant <= w_pick;
    end
  end

  // Per-packet beat count for the length watchdog; restarts on every new grant.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_beat_cnt <= '0;
    end else if (w_grant_ld) begin
      r_beat_cnt <= '0;
    end else if (w_xfer) begin
      r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
    end
  end

  // Inter-packet gap timer, running only while in GAP.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_gap_cnt <= '0;
    end else if ((r_state == ST_GAP) && (r_gap_cnt != GAP_LAST)) begin
      r_gap_cnt <= r_gap_cnt + GAP_W'(1);
    end else begin
      r_gap_cnt <= '0;
    end
  end

  // Completed-packet counters per source (wrapping) and saturating abort counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pkt_cnt0  <= '0;
      r_pkt_cnt1  <= '0;
      r_abort_cnt <= '0;
    end else begin
      if (w_pkt_done & r_grant[0]) r_pkt_cnt0 <= r_pkt_cnt0 + PKT_CNT_W'(1);
      if (w_pkt_done & r_grant[1]) r_pkt_cnt1 <= r_pkt_cnt1 + PKT_CNT_W'(1);
      if (w_abort_done)            r_abort_cnt <= sat_inc(r_abort_cnt);
    end
  end

endmodule

// File: tb/tb_tx_stream_arbiter.sv
// Scoreboard bench for tx_stream_arbiter: source queues feed beats, expected MAC beats are queued up front.
// Latency: checks each MAC transfer on the falling edge before it completes.
// Backpressure: sources hold their current beat until the arbiter accepts it.
module tb_tx_stream_arbiter;
  import tx_pkg::*;

  localparam int GAP = 2;
  localparam int MAXL = 1518;

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
  } beat_t;

  typedef struct packed {
    logic [1:0] src;
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic       err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        s0_req, s0_sop, s0_eop, s0_err, s0_wren, s0_rdy;
  logic        s1_req, s1_sop, s1_eop, s1_err, s1_wren, s1_rdy;
  logic [7:0]  s0_data, s1_data, tx_data;
  logic        tx_sop, tx_eop, tx_err, tx_wren, tx_rdy, tx_a_full;
  logic [15:0] pkt_cnt0, pkt_cnt1;
  logic [7:0]  abort_cnt;
  logic [1:0]  grant;

  beat_t      q0[$];
  beat_t      q1[$];
  exp_t       exp_q[$];
  logic [1:0] glog[$];
  int         gap_log[$];

  int   n_tests = 0;
  int   n_fail  = 0;
  int   xfer_cnt = 0;
  int   zero_run = 0;
  logic [1:0] prev_grant = 2'b00;
  bit   acc0, acc1, en0, en1;
  int   m_pkt0, m_pkt1, m_abort;

  tx_stream_arbiter #(.GAP_CYCLES(GAP), .MAX_LEN(MAXL)) dut (
    .clk(clk), .rst(rst),
    .s0_req(s0_req), .s0_data(s0_data), .s0_sop(s0_sop), .s0_eop(s0_eop),
    .s0_err(s0_err), .s0_wren(s0_wren), .s0_rdy(s0_rdy),
    .s1_req(s1_req), .s1_data(s1_data), .s1_sop(s1_sop), .s1_eop(s1_eop),
    .s1_err(s1_err), .s1_wren(s1_wren), .s1_rdy(s1_rdy),
    .tx_data(tx_data), .tx_sop(tx_sop), .tx_eop(tx_eop), .tx_err(tx_err),
    .tx_wren(tx_wren), .tx_rdy(tx_rdy), .tx_a_full(tx_a_full),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .abort_cnt(abort_cnt), .grant(grant)
  );

  always #5 clk = ~clk;

  function automatic bit all_done();
    return (q0.size() == 0) && (q1.size() == 0) && (exp_q.size() == 0);
  endfunction

  task automatic clear_logs();
    glog.delete();
    gap_log.delete();
    xfer_cnt   = 0;
    zero_run   = 0;
    prev_grant = 2'b00;
  endtask

  // Queue one packet at a source and the beats the MAC is expected to see for it.
  task automatic add_pkt(input int src, input int len, input int seed);
    beat_t b;
    exp_t  e;
    for (int i = 0; i < len; i++) begin
      b.data = 8'(seed + i);
      b.sop  = (i == 0);
      b.eop  = (i == len - 1);
      if (src == 0) q0.push_back(b); else q1.push_back(b);
      e.src  = (src == 0) ? 2'b01 : 2'b10;
      e.data = b.data;
      e.sop  = b.sop;
      e.eop  = b.eop;
      e.err  = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_sources();
    s0_req  = en0 && (q0.size() != 0);
    s0_wren = (q0.size() != 0);
    s0_err  = 1'b0;
    if (q0.size() != 0) begin
      s0_data = q0[0].data; s0_sop = q0[0].sop; s0_eop = q0[0].eop;
    end else begin
      s0_data = 8'h00; s0_sop = 1'b0; s0_eop = 1'b0;
    end
    s1_req  = en1 && (q1.size() != 0);
    s1_wren = (q1.size() != 0);
    s1_err  = 1'b0;
    if (q1.size() != 0) begin
      s1_data = q1[0].data; s1_sop = q1[0].sop; s1_eop = q1[0].eop;
    end else begin
      s1_data = 8'h00; s1_sop = 1'b0; s1_eop = 1'b0;
    end
  endtask

  // Falling-edge observation: rdy exclusivity, quiet bus when ungranted, scoreboard pop on transfer.
  task automatic monitor();
    exp_t got;
    exp_t e;
    acc0 = s0_wren && s0_rdy;
    acc1 = s1_wren && s1_rdy;
    n_tests++;
    if (grant == 2'b00) begin
      if ({tx_wren, tx_sop, tx_eop, tx_err, tx_data, s0_rdy, s1_rdy} !== 14'h0) begin
        n_fail++;
        $display("FAIL idle_quiet: wren=%b sop=%b eop=%b err=%b data=%h rdy0=%b rdy1=%b, want all 0",
                 tx_wren, tx_sop, tx_eop, tx_err, tx_data, s0_rdy, s1_rdy);
      end
    end else if (grant == 2'b01) begin
      if (s1_rdy !== 1'b0) begin
        n_fail++; $display("FAIL ungranted_rdy: s1_rdy=%b while grant=01, want 0", s1_rdy);
      end
    end else if (grant == 2'b10) begin
      if (s0_rdy !== 1'b0) begin
        n_fail++; $display("FAIL ungranted_rdy: s0_rdy=%b while grant=10, want 0", s0_rdy);
      end
    end else begin
      n_fail++; $display("FAIL grant_onehot: grant=%b, want 00/01/10", grant);
    end
    if (tx_wren && tx_rdy) begin
      xfer_cnt++;
      got = {grant, tx_data, tx_sop, tx_eop, tx_err};
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat: src=%b data=%h sop=%b eop=%b err=%b, want no transfer",
                 got.src, got.data, got.sop, got.eop, got.err);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL beat_%0d: got src=%b data=%h sop=%b eop=%b err=%b, want src=%b data=%h sop=%b eop=%b err=%b",
                   xfer_cnt, got.src, got.data, got.sop, got.eop, got.err, e.src, e.data, e.sop, e.eop, e.err);
        end
      end
    end
    if ((grant != 2'b00) && (prev_grant == 2'b00)) begin
      glog.push_back(grant);
      gap_log.push_back(zero_run);
    end
    zero_run   = (grant == 2'b00) ? zero_run + 1 : 0;
    prev_grant = grant;
  endtask

  task automatic step();
    beat_t dmy;
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    if (acc0 && (q0.size() != 0)) dmy = q0.pop_front();
    if (acc1 && (q1.size() != 0)) dmy = q1.pop_front();
    drive_sources();
  endtask

  task automatic drain(output bit ok);
    for (int c = 0; c < 4000; c++) begin
      if (all_done()) break;
      step();
    end
    ok = all_done();
    repeat (6) step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    s0_req = 1'b1; s1_req = 1'b1; s0_wren = 1'b1; s1_wren = 1'b1;
    s0_data = 8'hAA; s1_data = 8'h55; s0_sop = 1'b1; s1_sop = 1'b1;
    s0_eop = 1'b0; s1_eop = 1'b0; s0_err = 1'b0; s1_err = 1'b0;
    repeat (4) begin
      @(negedge clk);
      n_tests++;
      if ({grant, tx_wren, tx_sop, tx_eop, tx_err, tx_data, s0_rdy, s1_rdy, pkt_cnt0, pkt_cnt1, abort_cnt} !== 56'h0) begin
        n_fail++;
        $display("FAIL reset_state: grant=%b wren=%b rdy0=%b rdy1=%b cnt0=%0d cnt1=%0d abort=%0d, want all 0",
                 grant, tx_wren, s0_rdy, s1_rdy, pkt_cnt0, pkt_cnt1, abort_cnt);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_pkt0 = 0; m_pkt1 = 0; m_abort = 0;
    drive_sources();
    repeat (3) step();
  endtask

  task automatic test_alternate();
    bit ok;
    clear_logs();
    add_pkt(0, 64, 8'h10);
    add_pkt(1, 64, 8'h80);
    add_pkt(0, 64, 8'h20);
    add_pkt(1, 64, 8'hC0);
    drive_sources();
    drain(ok);
    m_pkt0 += 2; m_pkt1 += 2;
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL alt_timeout: exp left=%0d, want 0", exp_q.size()); end
    n_tests++;
    if (glog.size() != 4) begin
      n_fail++; $display("FAIL alt_grants: %0d grants, want 4", glog.size());
    end else begin
      n_tests++;
      if ({glog[0], glog[1], glog[2], glog[3]} !== 8'b01_10_01_10) begin
        n_fail++;
        $display("FAIL alt_order: %b %b %b %b, want 01 10 01 10", glog[0], glog[1], glog[2], glog[3]);
      end
      // Two GAP cycles plus the IDLE arbitration cycle separate consecutive grants.
      for (int i = 1; i < 4; i++) begin
        n_tests++;
        if (gap_log[i] != GAP + 1) begin
          n_fail++; $display("FAIL alt_gap_%0d: %0d ungranted cycles, want %0d", i, gap_log[i], GAP + 1);
        end
      end
    end
    n_tests++;
    if ({pkt_cnt0, pkt_cnt1} !== {16'(m_pkt0), 16'(m_pkt1)}) begin
      n_fail++; $display("FAIL alt_pkt_cnt: cnt0=%0d cnt1=%0d, want %0d %0d", pkt_cnt0, pkt_cnt1, m_pkt0, m_pkt1);
    end
  endtask

  task automatic test_a_full();
    bit ok;
    int base;
    clear_logs();
    add_pkt(0, 100, 8'h33);
    drive_sources();
    for (int c = 0; c < 500 && xfer_cnt < 40; c++) step();
    tx_a_full = 1'b1;
    base = xfer_cnt;
    repeat (3) step();
    n_tests++;
    if (xfer_cnt != base) begin
      n_fail++; $display("FAIL afull_stall: %0d beats moved during almost-full, want 0", xfer_cnt - base);
    end
    tx_a_full = 1'b0;
    drain(ok);
    m_pkt0 += 1;
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL afull_timeout: exp left=%0d, want 0", exp_q.size()); end
    n_tests++;
    if (xfer_cnt != 100) begin n_fail++; $display("FAIL afull_beats: %0d beats, want 100", xfer_cnt); end
    n_tests++;
    if (pkt_cnt0 !== 16'(m_pkt0)) begin
      n_fail++; $display("FAIL afull_pkt_cnt: cnt0=%0d, want %0d", pkt_cnt0, m_pkt0);
    end
  endtask

  task automatic test_req_drop();
    bit ok;
    clear_logs();
    add_pkt(0, 64, 8'h40);
    drive_sources();
    for (int c = 0; c < 500 && xfer_cnt < 10; c++) step();
    en0 = 1'b0;
    add_pkt(1, 32, 8'h90);
    drive_sources();
    drain(ok);
    en0 = 1'b1;
    m_pkt0 += 1; m_pkt1 += 1;
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL drop_timeout: exp left=%0d, want 0", exp_q.size()); end
    n_tests++;
    if (glog.size() != 2) begin
      n_fail++; $display("FAIL drop_grants: %0d grants, want 2", glog.size());
    end else begin
      n_tests++;
      if ({glog[0], glog[1], 8'(gap_log[1])} !== {2'b01, 2'b10, 8'(GAP + 1)}) begin
        n_fail++;
        $display("FAIL drop_order: %b then %b after %0d cycles, want 01 then 10 after %0d",
                 glog[0], glog[1], gap_log[1], GAP + 1);
      end
    end
    n_tests++;
    if ({pkt_cnt0, pkt_cnt1} !== {16'(m_pkt0), 16'(m_pkt1)}) begin
      n_fail++; $display("FAIL drop_pkt_cnt: cnt0=%0d cnt1=%0d, want %0d %0d", pkt_cnt0, pkt_cnt1, m_pkt0, m_pkt1);
    end
  endtask

  task automatic test_abort();
    bit    ok;
    beat_t b;
    exp_t  e;
    clear_logs();
    for (int i = 0; i < 1600; i++) begin
      b.data = 8'(i); b.sop = (i == 0); b.eop = 1'b0;
      q1.push_back(b);
      if (i < MAXL) begin
        e.src = 2'b10; e.data = b.data; e.sop = b.sop; e.eop = 1'b0; e.err = 1'b0;
        exp_q.push_back(e);
      end
    end
    b.data = 8'hEE; b.sop = 1'b0; b.eop = 1'b1;
    q1.push_back(b);
    e.src = 2'b10; e.data = 8'h00; e.sop = 1'b0; e.eop = 1'b1; e.err = 1'b1;
    exp_q.push_back(e);
    drive_sources();
    drain(ok);
    m_abort += 1;
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL abort_timeout: src left=%0d exp left=%0d, want 0 0", q1.size(), exp_q.size()); end
    n_tests++;
    if (xfer_cnt != MAXL + 1) begin n_fail++; $display("FAIL abort_beats: %0d beats, want %0d", xfer_cnt, MAXL + 1); end
    n_tests++;
    if ({abort_cnt, pkt_cnt1} !== {8'(m_abort), 16'(m_pkt1)}) begin
      n_fail++; $display("FAIL abort_cnts: abort=%0d cnt1=%0d, want %0d %0d", abort_cnt, pkt_cnt1, m_abort, m_pkt1);
    end
  endtask

  task automatic test_reset_mid_packet();
    bit ok;
    clear_logs();
    add_pkt(0, 64, 8'h05);
    add_pkt(1, 64, 8'hA0);
    drive_sources();
    for (int c = 0; c < 500 && xfer_cnt < 30; c++) step();
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({tx_wren, s0_rdy, s1_rdy} !== 3'b000) begin
      n_fail++; $display("FAIL rst_no_xfer: wren=%b rdy0=%b rdy1=%b in reset cycle, want 000", tx_wren, s0_rdy, s1_rdy);
    end
    @(posedge clk);
    #1;
    q0.delete(); q1.delete(); exp_q.delete();
    s0_req = 1'b1; s1_req = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({grant, tx_wren, tx_sop, tx_eop, tx_err, tx_data, s0_rdy, s1_rdy, pkt_cnt0, pkt_cnt1, abort_cnt} !== 56'h0) begin
      n_fail++;
      $display("FAIL rst_mid_state: grant=%b wren=%b data=%h cnt0=%0d cnt1=%0d abort=%0d, want all 0",
               grant, tx_wren, tx_data, pkt_cnt0, pkt_cnt1, abort_cnt);
    end
    m_pkt0 = 0; m_pkt1 = 0; m_abort = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    clear_logs();
    add_pkt(0, 16, 8'h60);
    add_pkt(1, 16, 8'h70);
    drive_sources();
    drain(ok);
    m_pkt0 += 1; m_pkt1 += 1;
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL rst_rearb_timeout: exp left=%0d, want 0", exp_q.size()); end
    n_tests++;
    if (glog.size() == 0 || glog[0] !== 2'b01) begin
      n_fail++; $display("FAIL rst_tie: first grant=%b (of %0d), want 01", (glog.size() != 0) ? glog[0] : 2'bxx, glog.size());
    end
    n_tests++;
    if ({pkt_cnt0, pkt_cnt1, abort_cnt} !== {16'(m_pkt0), 16'(m_pkt1), 8'(m_abort)}) begin
      n_fail++; $display("FAIL rst_cnts: cnt0=%0d cnt1=%0d abort=%0d, want %0d %0d %0d",
                         pkt_cnt0, pkt_cnt1, abort_cnt, m_pkt0, m_pkt1, m_abort);
    end
  endtask

  initial begin
    rst = 1'b0; tx_rdy = 1'b1; tx_a_full = 1'b0; en0 = 1'b1; en1 = 1'b1;
    acc0 = 1'b0; acc1 = 1'b0; m_pkt0 = 0; m_pkt1 = 0; m_abort = 0;
    drive_sources();
    test_reset();
    test_alternate();
    test_a_full();
    test_req_drop();
    test_abort();
    test_reset_mid_packet();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
